// File: rtl/Purple_Jade_pkg.sv
// Shared execute-stage types: opcodes, flag layout and the ROB/register writeback buses.
package Purple_Jade_pkg;

  localparam int unsigned WORD_SIZE_P  = 32;
  localparam int unsigned ROB_ENTRY    = 16;
  localparam int unsigned NUM_PHYS_REG = 64;

  localparam int unsigned ROB_TAG_W = $clog2(ROB_ENTRY);
  localparam int unsigned PREG_W    = $clog2(NUM_PHYS_REG);

  // Opcode space is wider than the eight logic ops so illegal encodings exist.
  localparam int unsigned WIDTH_OP = 4;
  localparam logic [WIDTH_OP-1:0] OP_AND  = 4'd0;
  localparam logic [WIDTH_OP-1:0] OP_XOR  = 4'd1;
  localparam logic [WIDTH_OP-1:0] OP_OR   = 4'd2;
  localparam logic [WIDTH_OP-1:0] OP_NEG  = 4'd3;
  localparam logic [WIDTH_OP-1:0] OP_LSLS = 4'd4;
  localparam logic [WIDTH_OP-1:0] OP_LSRS = 4'd5;
  localparam logic [WIDTH_OP-1:0] OP_ASRS = 4'd6;
  localparam logic [WIDTH_OP-1:0] OP_RORS = 4'd7;

  // Flags are packed {N,Z,C,V}, N in the MSB.
  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_N    = 3;
  localparam int unsigned FLAG_Z    = 2;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 0;

  typedef struct packed {
    logic                   valid;
    logic [PREG_W-1:0]      dest;
    logic [WORD_SIZE_P-1:0] result;
    logic [NUM_FLAGS-1:0]   flags;
  } cdb_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_dest;
    cdb_t                 cdb;
  } rob_wb_t;

  typedef struct packed {
    logic w_v;
    cdb_t cdb;
  } reg_wb_t;

  localparam int unsigned ROB_WB_WIDTH = $bits(rob_wb_t);
  localparam int unsigned REG_WB_WIDTH = $bits(reg_wb_t);

  // Stage payload width; units narrower than this zero-extend their result.
  localparam int unsigned FU_WIDTH = WORD_SIZE_P;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_dest;
    logic [PREG_W-1:0]    dest;
    logic [FU_WIDTH-1:0]  result;
    logic [NUM_FLAGS-1:0] flags;
  } fu_stage_t;

  function automatic logic is_legal_logic_op(input logic [WIDTH_OP-1:0] op);
    return op <= OP_RORS;
  endfunction

endpackage

// File: rtl/fu_logic_alu.sv
// Combinational logic/shift datapath producing the result and {N,Z,C,V} flags.
module fu_logic_alu
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned WIDTH_P = WORD_SIZE_P
) (
  input  logic [WIDTH_OP-1:0]  opcode_i,
  input  logic [WIDTH_P-1:0]   operand1_i,
  input  logic [WIDTH_P-1:0]   operand2_i,
  input  logic [NUM_FLAGS-1:0] flags_i,
  output logic [WIDTH_P-1:0]   result_o,
  output logic [NUM_FLAGS-1:0] flags_o,
  output logic                 illegal_o
);

  localparam int unsigned AmtW = $clog2(WIDTH_P) + 1;

  logic [AmtW-1:0]      amt;
  logic [2*WIDTH_P-1:0] lsl_ext;
  logic [2*WIDTH_P-1:0] lsr_ext;
  logic [2*WIDTH_P-1:0] asr_ext;
  logic [2*WIDTH_P-1:0] ror_ext;
  logic [WIDTH_P-1:0]   res;
  logic                 carry;
  logic                 is_shift;

  assign amt = operand2_i[AmtW-1:0];

  // Shifting into a double-width field leaves the last bit shifted out at the seam.
  assign lsl_ext = {{WIDTH_P{1'b0}}, operand1_i} << amt;
  assign lsr_ext = {operand1_i, {WIDTH_P{1'b0}}} >> amt;
  assign asr_ext = $signed({operand1_i, {WIDTH_P{1'b0}}}) >>> amt;
  assign ror_ext = {operand1_i, operand1_i} >> amt[AmtW-2:0];

  always_comb begin
    res       = '0;
    carry     = flags_i[FLAG_C];
    is_shift  = 1'b0;
    illegal_o = 1'b0;
    unique case (opcode_i)
      OP_AND: res = operand1_i & operand2_i;
      OP_XOR: res = operand1_i ^ operand2_i;
      OP_OR:  res = operand1_i | operand2_i;
      OP_NEG: res = -operand1_i;
      OP_LSLS: begin
        res      = lsl_ext[WIDTH_P-1:0];
        carry    = lsl_ext[WIDTH_P];
        is_shift = 1'b1;
      end
      OP_LSRS: begin
        res      = lsr_ext[2*WIDTH_P-1:WIDTH_P];
        carry    = lsr_ext[WIDTH_P-1];
        is_shift = 1'b1;
      end
      OP_ASRS: begin
        res      = asr_ext[2*WIDTH_P-1:WIDTH_P];
        carry    = asr_ext[WIDTH_P-1];
        is_shift = 1'b1;
      end
      OP_RORS: begin
        res      = ror_ext[WIDTH_P-1:0];
        carry    = ror_ext[WIDTH_P-1];
        is_shift = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    if (is_shift && (amt == '0)) begin
      carry = flags_i[FLAG_C];
    end
  end

  always_comb begin
    result_o = res;
    flags_o  = flags_i;
    if (!illegal_o) begin
      flags_o[FLAG_N] = res[WIDTH_P-1];
      flags_o[FLAG_Z] = (res == '0);
      flags_o[FLAG_C] = carry;
      flags_o[FLAG_V] = flags_i[FLAG_V];
    end
  end

endmodule

// File: rtl/fu_logic_pipe.sv
// Pipelined logic/shift functional unit: ALU ahead of a bubble-collapsing valid/ready pipe
// feeding the ROB and register-file writeback buses.
module fu_logic_pipe
  import Purple_Jade_pkg::*;
#(
  parameter int unsigned WIDTH_P  = WORD_SIZE_P,
  parameter int unsigned STAGES_P = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    exe_v_i,
  output logic                    ready_o,
  input  logic [WIDTH_OP-1:0]     opcode_i,
  input  logic [WIDTH_P-1:0]      operand1_i,
  input  logic [WIDTH_P-1:0]      operand2_i,
  input  logic [NUM_FLAGS-1:0]    flags_i,
  input  logic [ROB_TAG_W-1:0]    rob_dest_i,
  input  logic [PREG_W-1:0]       reg_dest_i,
  input  logic                    flush_i,
  input  logic                    out_ready_i,
  output logic                    out_v_o,
  output logic [ROB_WB_WIDTH-1:0] logic_rob_o,
  output logic [REG_WB_WIDTH-1:0] logic_reg_o
);

  localparam int unsigned Last = STAGES_P - 1;

  logic [WIDTH_P-1:0]   alu_result;
  logic [NUM_FLAGS-1:0] alu_flags;
  logic                 alu_illegal;
  fu_stage_t            issue_payload;

  logic [STAGES_P-1:0]  stage_v;
  logic [STAGES_P-1:0]  stage_load;
  fu_stage_t            stage_d [STAGES_P];

  rob_wb_t              rob_wb;
  reg_wb_t              reg_wb;

  fu_logic_alu #(
    .WIDTH_P (WIDTH_P)
  ) u_alu (
    .opcode_i   (opcode_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .flags_i    (flags_i),
    .result_o   (alu_result),
    .flags_o    (alu_flags),
    .illegal_o  (alu_illegal)
  );

  always_comb begin
    issue_payload          = '0;
    issue_payload.rob_dest = rob_dest_i;
    issue_payload.dest     = reg_dest_i;
    issue_payload.result   = FU_WIDTH'(alu_result);
    issue_payload.flags    = alu_flags;
  end

  // Stage k is blocked only if it and every stage after it are full and the CDB stalls.
  always_comb begin
    logic blocked;
    blocked    = !out_ready_i;
    stage_load = '0;
    for (int k = int'(Last); k >= 0; k--) begin
      blocked       = blocked && stage_v[k];
      stage_load[k] = !blocked;
    end
  end

  assign ready_o = stage_load[0];

  for (genvar g = 0; g < STAGES_P; g++) begin : gen_stage
    logic      in_v;
    fu_stage_t in_d;
    logic      v_q;
    fu_stage_t d_q;

    if (g == 0) begin : gen_head
      assign in_v = exe_v_i;
      assign in_d = issue_payload;
    end else begin : gen_body
      assign in_v = stage_v[g-1];
      assign in_d = stage_d[g-1];
    end

    // Flush only kills valid bits; a same-cycle issue is dropped along with them.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush_i) begin
        v_q <= 1'b0;
      end else if (stage_load[g]) begin
        v_q <= in_v;
        if (in_v) begin
          d_q <= in_d;
        end
      end
    end

    assign stage_v[g] = v_q;
    assign stage_d[g] = d_q;
  end

  assign out_v_o = stage_v[Last];

  always_comb begin
    rob_wb              = '0;
    rob_wb.rob_dest     = stage_d[Last].rob_dest;
    rob_wb.cdb.valid    = out_v_o;
    rob_wb.cdb.dest     = stage_d[Last].dest;
    rob_wb.cdb.result   = stage_d[Last].result;
    rob_wb.cdb.flags    = stage_d[Last].flags;
    reg_wb              = '0;
    reg_wb.w_v          = out_v_o;
    reg_wb.cdb          = rob_wb.cdb;
  end

  assign logic_rob_o = rob_wb;
  assign logic_reg_o = reg_wb;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && !flush_i && exe_v_i && ready_o && alu_illegal) begin
      $error("fu_logic_pipe: illegal opcode %0h accepted", opcode_i);
    end
  end
`endif

endmodule
